// File: rtl/seq_gen_engine.sv
// Sequence generator engine: fills an internal register file with a
// Fibonacci / arithmetic / XOR-lag / subtract-lag sequence from two seeds,
// one entry per cycle, with optional saturation and a sticky overflow flag.
// A registered read port is available in every state.
module seq_gen_engine #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int SAT   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [DW-1:0]              seed0,
  input  logic [DW-1:0]              seed1,
  input  logic [$clog2(DEPTH):0]     len,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DW-1:0]              rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam logic [AW:0] TWO_L   = (AW+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT0 = 3'd1,
    S_INIT1 = 3'd2,
    S_CALC  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DW-1:0]     seed0_q, seed0_d;
  logic [DW-1:0]     seed1_q, seed1_d;
  logic [AW:0]       len_q, len_d;
  logic [AW:0]       idx_q, idx_d;
  logic [DW-1:0]     prev1_q, prev1_d;
  logic [DW-1:0]     prev2_q, prev2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic [DW-1:0]     mem_q [DEPTH];

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW:0]       res;

  // Add with carry-out in the MSB; clamps to all-ones when saturating.
  function automatic logic [DW:0] add_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SAT != 0 && s[DW]) s = {1'b1, {DW{1'b1}}};
    return s;
  endfunction

  // Subtract with borrow in the MSB; clamps to zero when saturating.
  function automatic logic [DW:0] sub_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (SAT != 0 && s[DW]) s = {1'b1, {DW{1'b0}}};
    return s;
  endfunction

  // Requested length forced into 2..DEPTH.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    if (l < TWO_L)        return TWO_L;
    else if (l > DEPTH_L) return DEPTH_L;
    else                  return l;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: INIT0/INIT1 write the seeds, CALC writes until R[L-1].
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT0;
      S_INIT0: state_d = S_INIT1;
      S_INIT1: state_d = (len_q > TWO_L) ? S_CALC : S_FIN;
      S_CALC:  if (idx_q == len_q - ONE_L) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: run latches, write port, lag pipeline and flags.
  always_comb begin
    mode_d  = mode_q;
    seed0_d = seed0_q;
    seed1_d = seed1_q;
    len_d   = len_q;
    idx_d   = idx_q;
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = idx_q[AW-1:0];
    wr_data = '0;
    res     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          seed0_d = seed0;
          seed1_d = seed1;
          len_d   = clamp_len(len);
          idx_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_INIT0: begin
        wr_en   = 1'b1;
        wr_data = seed0_q;
        prev1_d = seed0_q;
        idx_d   = idx_q + ONE_L;
      end
      S_INIT1: begin
        // Mode 1 treats seed1 as the step, so R[1] is already seed0+step.
        if (mode_q == 2'd1) begin
          res   = add_op(prev1_q, seed1_q);
          ovf_d = ovf_q | res[DW];
          wr_data = res[DW-1:0];
        end else begin
          wr_data = seed1_q;
        end
        wr_en   = 1'b1;
        prev2_d = prev1_q;
        prev1_d = wr_data;
        idx_d   = idx_q + ONE_L;
      end
      S_CALC: begin
        case (mode_q)
          2'd0:    res = add_op(prev1_q, prev2_q);
          2'd1:    res = add_op(prev1_q, seed1_q);
          2'd2:    res = {1'b0, prev1_q ^ prev2_q};
          default: res = sub_op(prev1_q, prev2_q);
        endcase
        ovf_d   = ovf_q | res[DW];
        wr_en   = 1'b1;
        wr_data = res[DW-1:0];
        prev2_d = prev1_q;
        prev1_d = res[DW-1:0];
        idx_d   = idx_q + ONE_L;
      end
      S_FIN: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
    rd_data_d = ({1'b0, rd_addr} < DEPTH_L) ? mem_q[rd_addr] : '0;
  end

  // Control and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      seed0_q   <= '0;
      seed1_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      prev1_q   <= '0;
      prev2_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      mode_q    <= mode_d;
      seed0_q   <= seed0_d;
      seed1_q   <= seed1_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Sequence storage; a same-cycle read sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_seq_gen_engine.sv
// Directed bench for seq_gen_engine: three instances (32-bit wrap, 8-bit wrap,
// 8-bit saturating with a non-power-of-two depth) driven with shared stimulus.
module tb_seq_gen_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed0, seed1;
  logic [5:0]  len;
  logic [4:0]  rd_addr;

  logic        busy_a, done_a, ovf_a;
  logic [31:0] rd_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  rd_b;
  logic        busy_c, done_c, ovf_c;
  logic [7:0]  rd_c;

  int checks = 0;
  int errors = 0;

  seq_gen_engine #(.DW(32), .DEPTH(32), .SAT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .seed0(seed0), .seed1(seed1), .len(len),
    .busy(busy_a), .done(done_a), .ovf(ovf_a),
    .rd_addr(rd_addr), .rd_data(rd_a)
  );

  seq_gen_engine #(.DW(8), .DEPTH(20), .SAT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]), .len(len),
    .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .rd_addr(rd_addr), .rd_data(rd_b)
  );

  seq_gen_engine #(.DW(8), .DEPTH(20), .SAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]), .len(len),
    .busy(busy_c), .done(done_c), .ovf(ovf_c),
    .rd_addr(rd_addr), .rd_data(rd_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one run and watch 40 edges; exp_* is the edge count (after the
  // start edge) at which done must be seen, 0 means that instance is not judged.
  task automatic run(input logic [1:0] m, input logic [31:0] s0, input logic [31:0] s1,
                     input logic [5:0] l, input int exp_a, input int exp_bc, input bit restart);
    int cyc_a, cyc_b, cyc_c, cnt_a, cnt_b, cnt_c;
    cyc_a = 0; cyc_b = 0; cyc_c = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0;
    @(negedge clk);
    mode = m; seed0 = s0; seed1 = s1; len = l; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~m; seed0 = ~s0; seed1 = ~s1; len = 6'd0;
    for (int c = 1; c <= 40; c++) begin
      if (restart && c == 2) begin
        start = 1'b1; mode = 2'd1; seed0 = 32'd100; seed1 = 32'd100; len = 6'd2;
      end
      if (restart && c == exp_a - 1) start = 1'b0;
      @(posedge clk);
      #1;
      if (c == 1) chk("busy_after_start", 32'(busy_a), 32'd1);
      if (done_a) begin cnt_a++; if (cyc_a == 0) cyc_a = c; end
      if (done_b) begin cnt_b++; if (cyc_b == 0) cyc_b = c; end
      if (done_c) begin cnt_c++; if (cyc_c == 0) cyc_c = c; end
    end
    chk("done_cycle_a", 32'(cyc_a), 32'(exp_a));
    chk("done_count_a", 32'(cnt_a), 32'd1);
    chk("busy_idle_a", 32'(busy_a), 32'd0);
    if (exp_bc != 0) begin
      chk("done_cycle_b", 32'(cyc_b), 32'(exp_bc));
      chk("done_cycle_c", 32'(cyc_c), 32'(exp_bc));
      chk("done_count_b", 32'(cnt_b), 32'd1);
    end
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] or_b;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed0 = '0; seed1 = '0;
    len = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_rd", rd_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fibonacci, 32 entries; the 8-bit instances clamp to 20.
    run(2'd0, 32'd1, 32'd1, 6'd32, 33, 21, 1'b0);
    chk("fib32_ovf_a", 32'(ovf_a), 32'd0);
    rd(5'd31); chk("fib32_R31_a", rd_a, 32'd2178309);
    rd(5'd25); chk("fib32_R25_a", rd_a, 32'd121393);
    chk("oob_rd_b", 32'(rd_b), 32'd0);

    // Fibonacci, 16 entries: 8-bit wrap versus saturate.
    run(2'd0, 32'd1, 32'd1, 6'd16, 17, 17, 1'b0);
    rd(5'd12);
    chk("fib8_R12_b", 32'(rd_b), 32'd233);
    chk("fib8_R12_c", 32'(rd_c), 32'd233);
    rd(5'd13);
    chk("fib8_R13_b", 32'(rd_b), 32'd121);
    chk("fib8_R13_c", 32'(rd_c), 32'd255);
    chk("fib8_R13_a", rd_a, 32'd377);
    chk("fib8_ovf_b", 32'(ovf_b), 32'd1);
    chk("fib8_ovf_c", 32'(ovf_c), 32'd1);
    chk("fib16_ovf_a", 32'(ovf_a), 32'd0);
    rd(5'd25); chk("fib16_R25_kept_a", rd_a, 32'd121393);

    // Arithmetic step 5 + 3n, 4 entries; R[4] keeps the Fibonacci value 5.
    run(2'd1, 32'd5, 32'd3, 6'd4, 5, 5, 1'b0);
    rd(5'd0); chk("step_R0", rd_a, 32'd5);
    rd(5'd1); chk("step_R1", rd_a, 32'd8);
    rd(5'd2); chk("step_R2", rd_a, 32'd11);
    rd(5'd3); chk("step_R3", rd_a, 32'd14);
    rd(5'd4); chk("step_R4_kept", rd_a, 32'd5);
    chk("step_ovf", 32'(ovf_a), 32'd0);

    // Subtract-lag borrow: 2 - 5.
    run(2'd3, 32'd5, 32'd2, 6'd3, 4, 4, 1'b0);
    rd(5'd2);
    chk("sub_R2_a", rd_a, 32'hFFFF_FFFD);
    chk("sub_R2_b", 32'(rd_b), 32'hFD);
    chk("sub_R2_c", 32'(rd_c), 32'd0);
    chk("sub_ovf_a", 32'(ovf_a), 32'd1);
    chk("sub_ovf_c", 32'(ovf_c), 32'd1);

    // len=0 clamps to 2 entries; ovf cleared by the new start.
    run(2'd2, 32'd6, 32'd3, 6'd0, 3, 3, 1'b0);
    chk("len0_ovf", 32'(ovf_a), 32'd0);
    rd(5'd0); chk("len0_R0", rd_a, 32'd6);
    rd(5'd1); chk("len0_R1", rd_a, 32'd3);
    rd(5'd2); chk("len0_R2_kept", rd_a, 32'hFFFF_FFFD);

    // XOR-lag, 5 entries: 6,3,5,6,3.
    run(2'd2, 32'd6, 32'd3, 6'd5, 6, 6, 1'b0);
    rd(5'd2); chk("xor_R2", rd_a, 32'd5);
    rd(5'd3); chk("xor_R3", rd_a, 32'd6);
    rd(5'd4); chk("xor_R4", rd_a, 32'd3);

    // Start held high while busy must not disturb the run: 2,3,5,...,55.
    run(2'd0, 32'd2, 32'd3, 6'd8, 9, 9, 1'b1);
    rd(5'd7); chk("busy_R7", rd_a, 32'd55);
    rd(5'd6); chk("busy_R6", rd_a, 32'd34);
    rd(5'd8); chk("busy_R8_kept", rd_a, 32'd34);
    chk("busy_ovf", 32'(ovf_a), 32'd0);

    // Reset in the middle of CALC.
    @(negedge clk);
    mode = 2'd0; seed0 = 32'd1; seed1 = 32'd1; len = 6'd32; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_rd", rd_a, 32'd0);
    @(posedge clk);
    #1 chk("midrst_busy_b", 32'(busy_b), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    // Start on the very first edge after release: 2-entry XOR run.
    run(2'd2, 32'd6, 32'd3, 6'd1, 3, 3, 1'b0);
    or_b = '0;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      if (a == 0)      chk("postrst_R0", rd_a, 32'd6);
      else if (a == 1) chk("postrst_R1", rd_a, 32'd3);
      else begin
        chk($sformatf("postrst_R%0d", a), rd_a, 32'd0);
        or_b = or_b | rd_b;
      end
    end
    chk("postrst_b_cleared", 32'(or_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_gen_engine.md
SEQ_GEN_ENGINE -- requirements
Module: seq_gen_engine

Interface
REQ-001 SHALL have parameter DW, default 32, data width of every sequence entry.
REQ-002 SHALL have parameter DEPTH, default 32, number of internal storage entries (>=2).
REQ-003 SHALL have parameter SAT, default 0: 0 = wrap-around arithmetic, 1 = saturating arithmetic.
REQ-004 SHALL derive localparam AW = clog2(DEPTH), the address width.
REQ-005 SHALL have port clk  in  1: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  1: request a run; sampled only in IDLE.
REQ-008 SHALL have port mode  in  2: 0 = Fibonacci add, 1 = arithmetic step, 2 = XOR-lag, 3 = subtract-lag.
REQ-009 SHALL have ports seed0 and seed1  in  DW: initial values, or step for mode 1.
REQ-010 SHALL have port len  in  AW+1: number of entries to generate.
REQ-011 SHALL have port busy  out  1: run in progress.
REQ-012 SHALL have port done  out  1: one-cycle pulse at run end.
REQ-013 SHALL have port ovf  out  1: sticky overflow/borrow flag for the current or last run.
REQ-014 SHALL have port rd_addr  in  AW: read address.
REQ-015 SHALL have port rd_data  out  DW: registered read data.

Function
REQ-016 SHALL implement FSM states IDLE, INIT0, INIT1, CALC, FIN.
REQ-017 SHALL, in IDLE with start=1, latch mode, seed0, seed1 and clamped length L, clear ovf, set busy, and go to INIT0.
REQ-018 SHALL clamp L: len<2 gives L=2; len>DEPTH gives L=DEPTH.
REQ-019 SHALL, in INIT0, write R[0]=seed0 and go to INIT1.
REQ-020 SHALL, in INIT1, write R[1] = seed0+seed1 in mode 1 and seed1 in all other modes.
REQ-021 SHALL, from INIT1, go to CALC if L>2, else to FIN.
REQ-022 SHALL, in CALC, write one entry per cycle, R[n] for n = 2..L-1, with the operation selected by mode:
  - mode 0: R[n-1]+R[n-2]
  - mode 1: R[n-1]+step
  - mode 2: R[n-1]^R[n-2]
  - mode 3: R[n-1]-R[n-2]
REQ-023 SHALL hold R[n-1] and R[n-2] in internal pipeline registers so that no read-wait cycles are needed between writes.
REQ-024 SHALL go from CALC to FIN after the write of R[L-1].
REQ-025 SHALL, in FIN, assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-026 SHALL, for start sampled at edge k, write R[i] at edge k+1+i and assert done during the cycle following edge k+L+1.
REQ-027 SHALL ignore start while busy=1; no restart and no latch update occur.
REQ-028 SHALL set ovf when an add carries out of DW bits (modes 0 and 1) or a subtract borrows (mode 3).
REQ-029 SHALL keep ovf set until the next accepted start.
REQ-030 SHALL, with SAT=0, store results modulo 2^DW.
REQ-031 SHALL, with SAT=1, clamp add overflow to all-ones and subtract borrow to 0; ovf still sets.
REQ-032 SHALL leave entries at index >= L unchanged by a run.
REQ-033 SHALL update rd_data every cycle with R[rd_addr] one cycle after rd_addr is presented, in all states.
REQ-034 SHALL return 0 on rd_data when rd_addr>=DEPTH.
REQ-035 SHALL, on a read and write to the same address in the same cycle, return the old value.

Reset
REQ-036 SHALL, on rst_n low, immediately set FSM=IDLE, busy=0, done=0, ovf=0, rd_data=0, all entries R[*]=0, and all latches and pipeline registers to 0.
REQ-037 SHALL, on reset mid-run, abort the run with no done pulse.
REQ-038 SHALL accept start again in the first cycle after rst_n rises.

Verification
REQ-039 SHALL cover: DW=32, DEPTH=32, mode 0, seeds 1/1, len=32 -> R[31]=2178309, done one cycle after edge k+33, ovf=0.
REQ-040 SHALL cover: DW=8, SAT=0, mode 0, seeds 1/1, len=16 -> R[12]=233, R[13]=121, ovf=1; same run with SAT=1 -> R[13]=255.
REQ-041 SHALL cover: mode 1, seed0=5, seed1=3, len=4 -> R[0..3]=5,8,11,14, R[4] unchanged, ovf=0.
REQ-042 SHALL cover: mode 3, seeds 5/2, len=3 -> R[2]=0xFFFFFFFD with SAT=0 (0 with SAT=1), ovf=1; len=0 -> L=2, done one cycle after edge k+3.
REQ-043 SHALL cover: start pulsed again while busy -> ignored, results identical to a single run.
REQ-044 SHALL cover: rst_n low during CALC -> busy=0, no done, every rd_addr reads 0.
